// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Main control FSM of the multicycle RV32I core. It walks each instruction
//   through fetch, decode, execute, memory and writeback in 3-5 cycles. It
//   stalls on the memory-ready handshake. It falls into a sticky trap state
//   on any encoding it does not support.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-low reset (0 = reset)
//   op         instruction[6:0]
//   funct3     instruction[14:12]
//   funct7b5   instruction[30]
//   Zero       ALU zero flag
//   MemReady   memory has completed the current access
//   ALUControl ALU operation (0000 ADD .. 1001 SLTU)
//   ALUSrcA    A select: 00 PC, 01 OldPC, 10 rs1, 11 zero
//   ALUSrcB    B select: 00 rs2, 01 ImmExt, 10 constant 4
//   ResultSrc  Result select: 00 ALUOut, 01 Data, 10 ALUResult
//   ImmSrc     immediate format: 000 I, 001 S, 010 B, 011 J, 100 U
//   AdrSrc     memory address: 0 PC, 1 Result
//   IRWrite, PCWrite, RegWrite, MemWrite  write enables
//   Illegal    trap indicator
module multicycle_controller #(
    parameter int NUM_STATES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic [3:0] ALUControl,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [2:0] ImmSrc,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       Illegal
);

    localparam int SW = $clog2(NUM_STATES);

    typedef enum logic [SW-1:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
        ALUWB, BRANCH, JAL, JALR, JALR2, LUI, AUIPC, TRAP
    } state_t;

    localparam logic [3:0] A_ADD  = 4'b0000;
    localparam logic [3:0] A_SUB  = 4'b0001;
    localparam logic [3:0] A_AND  = 4'b0010;
    localparam logic [3:0] A_OR   = 4'b0011;
    localparam logic [3:0] A_XOR  = 4'b0100;
    localparam logic [3:0] A_SLT  = 4'b0101;
    localparam logic [3:0] A_SLL  = 4'b0110;
    localparam logic [3:0] A_SRL  = 4'b0111;
    localparam logic [3:0] A_SRA  = 4'b1000;
    localparam logic [3:0] A_SLTU = 4'b1001;

    state_t state, next;

    // R-type honours funct7b5 for ADD/SUB and SRL/SRA. I-type honours it only for
    // shifts, because addi has immediate bits in that position.
    function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic f7, input logic rtype);
        case (f3)
            3'b000:  alu_dec = (rtype && f7) ? A_SUB : A_ADD;
            3'b001:  alu_dec = A_SLL;
            3'b010:  alu_dec = A_SLT;
            3'b011:  alu_dec = A_SLTU;
            3'b100:  alu_dec = A_XOR;
            3'b101:  alu_dec = f7 ? A_SRA : A_SRL;
            3'b110:  alu_dec = A_OR;
            default: alu_dec = A_AND;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) state <= FETCH;
        else        state <= next;
    end

    // Immediate format follows the opcode in every state.
    always_comb begin
        ImmSrc = 3'b000;
        case (op)
            7'b0000011, 7'b1100111, 7'b0010011: ImmSrc = 3'b000;
            7'b0100011:                         ImmSrc = 3'b001;
            7'b1100011:                         ImmSrc = 3'b010;
            7'b1101111:                         ImmSrc = 3'b011;
            7'b0110111, 7'b0010111:             ImmSrc = 3'b100;
            default:                            ImmSrc = 3'b000;
        endcase
    end

    always_comb begin
        next       = state;
        ALUControl = A_ADD;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        Illegal    = 1'b0;
        case (state)
            FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
                if (MemReady) next = DECODE;
            end
            DECODE: begin
                // Precompute OldPC + imm into ALUOut for branch/jal targets.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    7'b0000011, 7'b0100011: next = MEMADR;
                    7'b0110011:             next = EXECR;
                    7'b0010011:             next = EXECI;
                    7'b1100011:             next = BRANCH;
                    7'b1101111:             next = JAL;
                    7'b1100111:             next = JALR;
                    7'b0110111:             next = LUI;
                    7'b0010111:             next = AUIPC;
                    default:                next = TRAP;
                endcase
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                next    = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
                if (MemReady) next = MEMWB;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                next      = FETCH;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (MemReady) next = FETCH;
            end
            EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_dec(funct3, funct7b5, 1'b1);
                next       = ALUWB;
            end
            EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_dec(funct3, funct7b5, 1'b0);
                next       = ALUWB;
            end
            ALUWB: begin
                RegWrite = 1'b1;
                next     = FETCH;
            end
            BRANCH: begin
                ALUSrcA = 2'b10;
                next    = FETCH;
                // funct3[0] inverts the sense of Zero; funct3[2:1] picks the compare.
                case (funct3)
                    3'b000, 3'b001: ALUControl = A_SUB;
                    3'b100, 3'b101: ALUControl = A_SLT;
                    3'b110, 3'b111: ALUControl = A_SLTU;
                    default:        next = TRAP;
                endcase
                if (funct3[2:1] != 2'b01) begin
                    // The SUB-based compares are taken on Zero, and the SLT-based ones on
                    // !Zero. bne, bge and bgeu invert that.
                    PCWrite = (funct3[2] ? ~Zero : Zero) ^ funct3[0];
                end
            end
            JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                next    = ALUWB;
            end
            JALR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                next    = JALR2;
            end
            JALR2: begin
                // The target in ALUOut goes to the PC while OldPC+4 is formed for rd.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                next    = ALUWB;
            end
            LUI: begin
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b01;
                next    = ALUWB;
            end
            AUIPC: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                next    = ALUWB;
            end
            TRAP: begin
                Illegal = 1'b1;
            end
            default: next = TRAP;
        endcase

        // While reset is held, nothing may be written, even though the state
        // register has not yet loaded FETCH.
        if (!reset) begin
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            Illegal  = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       MemReady;
    logic [3:0] ALUControl;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [2:0] ImmSrc;
    logic       AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, Illegal;

    int n_cmp = 0;
    int n_err = 0;

    multicycle_controller #(.NUM_STATES(16)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .MemReady(MemReady), .ALUControl(ALUControl), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .AdrSrc(AdrSrc),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    // Enables packed as {IRWrite, PCWrite, RegWrite, MemWrite, Illegal}
    wire [4:0] en = {IRWrite, PCWrite, RegWrite, MemWrite, Illegal};

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then settle 1 time unit past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; MemReady = 1'b1; Zero = 1'b0;
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;   // sub
        tick();
        chk("rst_en_c1", 8'(en), 8'h00);
        tick();
        chk("rst_en_c2", 8'(en), 8'h00);

        // FETCH after release
        reset = 1'b1; #1;
        chk("fetch_en", 8'(en), 8'b11000);
        chk("fetch_aluctl", 8'(ALUControl), 8'h0);
        chk("fetch_srcb", 8'(ALUSrcB), 8'h2);
        chk("fetch_srca", 8'(ALUSrcA), 8'h0);
        chk("fetch_res", 8'(ResultSrc), 8'h2);
        chk("fetch_adr", 8'(AdrSrc), 8'h0);
        tick();                                       // DECODE
        chk("dec_srca", 8'(ALUSrcA), 8'h1);
        chk("dec_srcb", 8'(ALUSrcB), 8'h1);
        chk("dec_en", 8'(en), 8'h00);
        tick();                                       // EXECR
        chk("sub_aluctl", 8'(ALUControl), 8'h1);
        chk("sub_srca", 8'(ALUSrcA), 8'h2);
        chk("sub_srcb", 8'(ALUSrcB), 8'h0);
        tick();                                       // ALUWB
        chk("sub_wb_en", 8'(en), 8'b00100);
        chk("sub_wb_res", 8'(ResultSrc), 8'h0);
        tick();                                       // FETCH
        chk("sub_refetch", 8'(en), 8'b11000);

        // srai
        op = 7'b0010011; funct3 = 3'b101; funct7b5 = 1'b1;
        tick(); tick();                               // EXECI
        chk("srai_aluctl", 8'(ALUControl), 8'h8);
        chk("srai_srcb", 8'(ALUSrcB), 8'h1);
        chk("srai_imm", 8'(ImmSrc), 8'h0);
        tick(); tick();                               // FETCH
        // addi with instruction[30] set
        funct3 = 3'b000; funct7b5 = 1'b1;
        tick(); tick();
        chk("addi_aluctl", 8'(ALUControl), 8'h0);
        tick(); tick();
        chk("addi_refetch", 8'(en), 8'b11000);

        // beq taken
        op = 7'b1100011; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b1;
        tick();
        chk("br_imm", 8'(ImmSrc), 8'h2);
        tick();                                       // BRANCH
        chk("beq_en", 8'(en), 8'b01000);
        chk("beq_aluctl", 8'(ALUControl), 8'h1);
        tick();
        chk("beq_refetch", 8'(en), 8'b11000);
        // bge not taken
        funct3 = 3'b101; Zero = 1'b0;
        tick(); tick();
        chk("bge_pcw", 8'(PCWrite), 8'h0);
        chk("bge_aluctl", 8'(ALUControl), 8'h5);
        tick();
        // bltu, Zero=0 -> taken
        funct3 = 3'b110;
        tick(); tick();
        chk("bltu_aluctl", 8'(ALUControl), 8'h9);
        chk("bltu_pcw", 8'(PCWrite), 8'h1);
        tick();
        chk("bltu_refetch", 8'(en), 8'b11000);

        // lw with 3 wait cycles
        op = 7'b0000011; funct3 = 3'b010;
        tick(); tick();                               // MEMADR
        chk("lw_adr_srca", 8'(ALUSrcA), 8'h2);
        chk("lw_adr_srcb", 8'(ALUSrcB), 8'h1);
        MemReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();                                   // MEMREAD held
            chk($sformatf("lw_wait%0d_adr", i), 8'(AdrSrc), 8'h1);
            chk($sformatf("lw_wait%0d_en", i), 8'(en), 8'h00);
        end
        MemReady = 1'b1;
        tick();                                       // MEMWB
        chk("lw_wb_res", 8'(ResultSrc), 8'h1);
        chk("lw_wb_en", 8'(en), 8'b00100);
        tick();
        chk("lw_refetch", 8'(en), 8'b11000);

        // sw with 3 wait cycles
        op = 7'b0100011;
        #1;
        chk("sw_imm", 8'(ImmSrc), 8'h1);
        tick(); tick();
        MemReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();                                   // MEMWRITE held
            chk($sformatf("sw_wait%0d_en", i), 8'(en), 8'b00010);
        end
        MemReady = 1'b1; #1;
        chk("sw_done_en", 8'(en), 8'b00010);
        tick();
        chk("sw_refetch", 8'(en), 8'b11000);

        // FETCH stalls without MemReady
        MemReady = 1'b0; #1;
        chk("fetch_stall_en", 8'(en), 8'h00);
        tick();
        chk("fetch_stall_srcb", 8'(ALUSrcB), 8'h2);
        MemReady = 1'b1; #1;
        chk("fetch_stall_rel", 8'(en), 8'b11000);

        // jal
        op = 7'b1101111;
        tick(); tick();                               // JAL
        chk("jal_en", 8'(en), 8'b01000);
        chk("jal_srca", 8'(ALUSrcA), 8'h1);
        chk("jal_srcb", 8'(ALUSrcB), 8'h2);
        chk("jal_imm", 8'(ImmSrc), 8'h3);
        tick();
        chk("jal_wb_en", 8'(en), 8'b00100);
        tick();
        chk("jal_refetch", 8'(en), 8'b11000);

        // illegal opcode -> sticky trap
        op = 7'b1111111;
        tick(); tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("trap%0d_en", i), 8'(en), 8'b00001);
            tick();
        end
        reset = 1'b0; #1;
        chk("trap_rst_en", 8'(en), 8'h00);
        tick();
        reset = 1'b1; op = 7'b0110011; #1;
        chk("trap_rst_refetch", 8'(en), 8'b11000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
